cnn_frame_sequencer: RTL
========================

// Module: cnn_frame_sequencer
// PURPOSE
//  Sequences one input frame through the CNN pipeline, row by row.
//  - Pops image rows from the input FIFO and presents each to the first line buffer.
//  - Waits for conv layer 1 to consume each row before fetching the next.
//  - After the last row, waits for the dense layer result, then reports frame completion.
//  - Provides the start/busy/done control handshake and a watchdog for stalled pipelines.
// PARAMETERS
//  H        24     rows per input frame
//  TIMEOUT  4096   max cycles spent in WAIT_ACK or DRAIN before error abort
//  CNT_W    5      width of row_cnt_o (must hold H)
//  TMO_W    13     width of watchdog counter (must hold TIMEOUT)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  reset          in   1      asynchronous, active-high reset
//  start_i        in   1      frame start request, sampled only in IDLE
//  fifo_empty_i   in   1      input FIFO empty flag
//  fifo_ren_o     out  1      FIFO read enable; o_rdata is valid the next cycle
//  row_valid_o    out  1      1-cycle pulse to line buffer valid_i: FIFO row valid
//  conv1_done_i   in   1      conv layer 1 done: row consumed, next row may be sent
//  dense_valid_i  in   1      dense layer output valid, frame result ready
//  busy_o         out  1      high in every state except IDLE
//  done_o         out  1      1-cycle pulse, frame completed normally
//  row_cnt_o      out  CNT_W  rows presented so far in the current frame
//  err_o          out  1      sticky watchdog error flag, cleared by an accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; row and watchdog counters 0.
//  FSM states: IDLE, FETCH, PRESENT, WAIT_ACK, DRAIN, DONE.
//  - IDLE: when start_i=1, clear row_cnt_o and err_o, then go to FETCH.
//    start_i in any other state is ignored; no queueing.
//  - FETCH: fifo_ren_o=1 combinationally only while fifo_empty_i=0.
//    Go to PRESENT on the same edge that the pop happens.
//    If the FIFO is empty, stay in FETCH; the watchdog does not run here.
//  - PRESENT: row_valid_o=1 for exactly this one cycle, aligned with FIFO o_rdata.
//    row_cnt_o increments on the exit edge; go to WAIT_ACK.
//  - WAIT_ACK: wait for conv1_done_i=1.
//    On conv1_done_i: if row_cnt_o==H go to DRAIN, else go to FETCH.
//  - DRAIN: wait for dense_valid_i=1, then go to DONE.
//  - DONE: done_o=1 for one cycle, then go to IDLE.
//  Latency:
//  - Minimum of 3 cycles per row: FETCH -> PRESENT -> WAIT_ACK, with ack in the first WAIT_ACK cycle.
//  - start_i to first fifo_ren_o: 1 cycle.
//  Watchdog:
//  - Cleared on entry to WAIT_ACK and to DRAIN; increments each cycle spent in those states.
//  - When it reaches TIMEOUT-1 with no awaited event, set err_o=1 and go to IDLE; done_o is not pulsed.
//  - An awaited event arriving in that same cycle wins and no error is raised.
//  Stray strobes:
//  - conv1_done_i outside WAIT_ACK and dense_valid_i outside DRAIN are ignored.
//  - A dense_valid_i during WAIT_ACK of row H is not remembered; DRAIN waits for a new pulse.
//  Width: row_cnt_o saturates at H and never wraps; H must be < 2**CNT_W.
//  Reset asserted mid-frame: immediate return to IDLE with all outputs 0.
//  - FIFO contents are not flushed by this block.
//  fifo_ren_o is never high outside FETCH, so at most one row is in flight at a time.
// TESTING
//  1 Normal frame, H=24, FIFO holds 24 rows, conv1_done 2 cycles after each row_valid:
//    -> 24 row_valid_o pulses, row_cnt_o=24, then dense_valid -> done_o 1 cycle later, busy_o=0.
//  2 FIFO empty for 10 cycles before row 5 -> fifo_ren_o stays 0 and no row_valid_o during those cycles;
//    resumes when not empty; err_o=0.
//  3 TIMEOUT=16, conv1_done_i never returned after row 3 -> err_o=1 16 cycles after entering WAIT_ACK;
//    state IDLE, done_o=0; the next start_i clears err_o.
//  4 start_i pulsed during WAIT_ACK and during DRAIN; conv1_done_i pulsed during DRAIN
//    -> no effect; exactly 24 rows and one done_o.
//  5 reset asserted in WAIT_ACK of row 7 -> all outputs 0 asynchronously;
//    after release, start_i begins a new frame with row_cnt_o counting from 0.
//  6 conv1_done_i arriving exactly on the watchdog's final cycle -> normal progress to FETCH, err_o=0.

Source files
------------

// File: rtl/cnn_frame_sequencer_if.sv
// Control bundle between the frame sequencer and the CNN pipeline around it:
// start request, input FIFO pop handshake, per-row line-buffer strobe,
// layer acknowledgements and frame status.
interface cnn_frame_sequencer_if #(
  parameter int CNT_W = 5
);
  logic             start_i;
  logic             fifo_empty_i;
  logic             fifo_ren_o;
  logic             row_valid_o;
  logic             conv1_done_i;
  logic             dense_valid_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] row_cnt_o;
  logic             err_o;

  // The sequencer drives the control outputs and watches the pipeline.
  modport master (
    input  start_i, fifo_empty_i, conv1_done_i, dense_valid_i,
    output fifo_ren_o, row_valid_o, busy_o, done_o, row_cnt_o, err_o
  );

  // The surrounding pipeline sees the mirror image.
  modport slave (
    output start_i, fifo_empty_i, conv1_done_i, dense_valid_i,
    input  fifo_ren_o, row_valid_o, busy_o, done_o, row_cnt_o, err_o
  );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer: pops one image row at a time from the input FIFO, presents
// it to the first line buffer, waits for conv layer 1 to consume it, and after
// the last row waits for the dense layer result before flagging completion.
// A watchdog aborts the frame if the pipeline stalls in a waiting state.
module cnn_frame_sequencer #(
  parameter int H       = 24,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 5,
  parameter int TMO_W   = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  cnn_frame_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_WAIT_ACK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] row_cnt;
  logic [TMO_W-1:0] wdog;
  logic             wdog_expired;
  logic             abort;
  logic             start_accept;
  logic             last_row;

  assign wdog_expired = (wdog == TMO_W'(TIMEOUT - 1));
  assign start_accept = (state == S_IDLE) && bus.start_i;
  assign last_row     = (row_cnt == CNT_W'(H));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; an awaited event beats a watchdog expiry in the same cycle.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a value
    // unassigned, which would infer a latch.
    state_next = state;
    abort      = 1'b0;
    unique case (state)
      S_IDLE:    if (bus.start_i) state_next = S_FETCH;
      S_FETCH:   if (!bus.fifo_empty_i) state_next = S_PRESENT;
      S_PRESENT: state_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (bus.conv1_done_i) begin
          state_next = last_row ? S_DRAIN : S_FETCH;
        end else if (wdog_expired) begin
          state_next = S_IDLE;
          abort      = 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.dense_valid_i) begin
          state_next = S_DONE;
        end else if (wdog_expired) begin
          state_next = S_IDLE;
          abort      = 1'b1;
        end
      end
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Moore-style outputs; the FIFO pop is gated by the empty flag so a pop
  // only ever happens on the edge that moves FETCH to PRESENT.
  always_comb begin
    bus.fifo_ren_o  = 1'b0;
    bus.row_valid_o = 1'b0;
    bus.busy_o      = 1'b0;
    bus.done_o      = 1'b0;
    unique case (state)
      S_IDLE:    ;
      S_FETCH: begin
        bus.busy_o     = 1'b1;
        bus.fifo_ren_o = !bus.fifo_empty_i;
      end
      S_PRESENT: begin
        bus.busy_o      = 1'b1;
        bus.row_valid_o = 1'b1;
      end
      S_DONE: begin
        bus.busy_o = 1'b1;
        bus.done_o = 1'b1;
      end
      default:   bus.busy_o = 1'b1;
    endcase
  end

  // Row counter: cleared by an accepted start, bumped when a row leaves
  // PRESENT, saturating at H.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt <= '0;
    end else if (start_accept) begin
      row_cnt <= '0;
    end else if (state == S_PRESENT && !last_row) begin
      row_cnt <= row_cnt + CNT_W'(1);
    end
  end

  // Watchdog: runs only while staying in WAIT_ACK or DRAIN, so it restarts
  // from zero on every entry into either state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog <= '0;
    end else if ((state == S_WAIT_ACK || state == S_DRAIN) && state_next == state) begin
      wdog <= wdog + TMO_W'(1);
    end else begin
      wdog <= '0;
    end
  end

  // Sticky error flag: set on a watchdog abort, cleared by the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.err_o <= 1'b0;
    end else if (start_accept) begin
      bus.err_o <= 1'b0;
    end else if (abort) begin
      bus.err_o <= 1'b1;
    end
  end

  assign bus.row_cnt_o = row_cnt;

endmodule
